// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU lab sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    SHOW_A,
    SHOW_B,
    WAIT_OP,
    EXEC,
    SHOW_R,
    ABORT
  } state_t;

  localparam logic MUX_LFSR = 1'b0;
  localparam logic MUX_ALU  = 1'b1;

  localparam int LED_A   = 0;
  localparam int LED_B   = 1;
  localparam int LED_OP0 = 2;

endpackage

// File: rtl/alu_seq_ctrl_dwell_timer.sv
// Dwell timer for the display states: counts cycles since state entry, or
// defers to the advance request when single-stepping.
module dwell_timer #(
  parameter int DISP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic step_mode,
  input  logic advance,
  output logic expire
);

  localparam int CW = $clog2(DISP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DISP_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  // Saturates on the last dwell cycle so a long step-mode hold cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LAST) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expire = step_mode ? advance : (cnt_reg == LAST);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Operation sequencer for the lab datapath: loads two LFSR operands, shows
// them, waits for an ALU button, writes the result back and shows it.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int N_OPS       = 10,
  parameter int REG_AW      = 5,
  parameter int N_ALU_OPS   = 4,
  parameter int DISP_CYCLES = 2
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [N_ALU_OPS-1:0]                              alu_btn,
  input  logic                                              skip,
  input  logic                                              step_mode,
  input  logic                                              advance,
  output logic                                              muxctrl,
  output logic                                              we_reg,
  output logic                                              we_lfsr,
  output logic [REG_AW-1:0]                                 addr_rd,
  output logic [REG_AW-1:0]                                 addr_rs1,
  output logic [REG_AW-1:0]                                 addr_rs2,
  output logic [((N_ALU_OPS > 1) ? $clog2(N_ALU_OPS) : 1)-1:0] aluctrl,
  output logic [N_ALU_OPS+1:0]                              leds,
  output logic                                              displayctrl,
  output logic [$clog2(N_OPS+1)-1:0]                        op_idx,
  output logic                                              done
);

  localparam int OPW = (N_ALU_OPS > 1) ? $clog2(N_ALU_OPS) : 1;
  localparam int IW  = $clog2(N_OPS + 1);
  localparam logic [IW-1:0] LAST_OP = IW'(N_OPS - 1);

  state_t            state_reg, state_next;
  logic [IW-1:0]     op_idx_reg, op_idx_next;
  logic [OPW-1:0]    op_q_reg, op_q_next;
  logic              done_reg, done_next;
  logic [OPW-1:0]    btn_idx;
  logic              btn_any;
  logic              expire;
  logic              dwell_start;
  logic [REG_AW-1:0] base;

  // Descending scan so the lowest set button is the one left standing.
  always_comb begin
    btn_idx = '0;
    for (int i = N_ALU_OPS - 1; i >= 0; i--) begin
      if (alu_btn[i]) begin
        btn_idx = OPW'(i);
      end
    end
  end

  assign btn_any     = |alu_btn;
  assign dwell_start = (state_next != state_reg);
  assign base        = REG_AW'(op_idx_reg) * REG_AW'(3);

  dwell_timer #(
    .DISP_CYCLES(DISP_CYCLES)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dwell_start),
    .step_mode(step_mode),
    .advance  (advance),
    .expire   (expire)
  );

  always_comb begin
    state_next  = state_reg;
    op_idx_next = op_idx_reg;
    op_q_next   = op_q_reg;
    done_next   = 1'b0;
    case (state_reg)
      LOAD_A:  state_next = skip ? ABORT : LOAD_B;
      LOAD_B:  state_next = skip ? ABORT : SHOW_A;
      SHOW_A: begin
        if (skip)        state_next = ABORT;
        else if (expire) state_next = SHOW_B;
      end
      SHOW_B: begin
        if (skip)        state_next = ABORT;
        else if (expire) state_next = WAIT_OP;
      end
      WAIT_OP: begin
        if (skip) begin
          state_next = ABORT;
        end else if (btn_any) begin
          op_q_next  = btn_idx;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = SHOW_R;
      SHOW_R: begin
        if (skip || expire) begin
          state_next = LOAD_A;
          if (op_idx_reg == LAST_OP) begin
            op_idx_next = '0;
            done_next   = 1'b1;
          end else begin
            op_idx_next = op_idx_reg + IW'(1);
          end
        end
      end
      ABORT:   state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= LOAD_A;
      op_idx_reg <= '0;
      op_q_reg   <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_idx_reg <= op_idx_next;
      op_q_reg   <= op_q_next;
      done_reg   <= done_next;
    end
  end

  // Outputs are forced low while reset is held so nothing writes the regfile.
  always_comb begin
    muxctrl     = MUX_LFSR;
    we_reg      = 1'b0;
    we_lfsr     = 1'b0;
    addr_rd     = '0;
    addr_rs1    = '0;
    addr_rs2    = '0;
    aluctrl     = '0;
    leds        = '0;
    displayctrl = 1'b0;
    if (rst_n) begin
      case (state_reg)
        LOAD_A: begin
          we_lfsr = 1'b1;
          we_reg  = 1'b1;
          addr_rd = base;
        end
        LOAD_B: begin
          we_lfsr = 1'b1;
          we_reg  = 1'b1;
          addr_rd = base + REG_AW'(1);
        end
        SHOW_A: begin
          displayctrl = 1'b1;
          addr_rs2    = base;
          leds[LED_A] = 1'b1;
        end
        SHOW_B: begin
          displayctrl = 1'b1;
          addr_rs2    = base + REG_AW'(1);
          leds[LED_B] = 1'b1;
        end
        WAIT_OP: begin
          addr_rs1 = base;
          addr_rs2 = base + REG_AW'(1);
        end
        EXEC: begin
          muxctrl  = MUX_ALU;
          we_reg   = 1'b1;
          addr_rd  = base + REG_AW'(2);
          addr_rs1 = base;
          addr_rs2 = base + REG_AW'(1);
          aluctrl  = op_q_reg;
          leds[LED_OP0 + int'(op_q_reg)] = 1'b1;
        end
        SHOW_R: begin
          displayctrl = 1'b1;
          addr_rs2    = base + REG_AW'(2);
          aluctrl     = op_q_reg;
          leds[LED_OP0 + int'(op_q_reg)] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign op_idx = op_idx_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a behavioural model of the operation sequence.
module tb_alu_seq_ctrl;

  localparam int N_OPS = 10;
  localparam int REG_AW = 5;
  localparam int N_ALU_OPS = 4;
  localparam int DISP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] alu_btn = '0;
  logic skip = 1'b0;
  logic step_mode = 1'b0;
  logic advance = 1'b0;
  logic muxctrl, we_reg, we_lfsr, displayctrl, done;
  logic [4:0] addr_rd, addr_rs1, addr_rs2;
  logic [1:0] aluctrl;
  logic [5:0] leds;
  logic [3:0] op_idx;

  int total = 0;
  int bad = 0;

  alu_seq_ctrl #(
    .N_OPS(N_OPS), .REG_AW(REG_AW), .N_ALU_OPS(N_ALU_OPS), .DISP_CYCLES(DISP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alu_btn(alu_btn), .skip(skip),
    .step_mode(step_mode), .advance(advance), .muxctrl(muxctrl),
    .we_reg(we_reg), .we_lfsr(we_lfsr), .addr_rd(addr_rd),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .aluctrl(aluctrl),
    .leds(leds), .displayctrl(displayctrl), .op_idx(op_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_LOAD_A, P_LOAD_B, P_SHOW_A, P_SHOW_B, P_WAIT, P_EXEC, P_SHOW_R, P_ABORT} phase_t;
  phase_t m_ph = P_LOAD_A;
  int m_el = 0;
  int m_idx = 0;
  int m_op = 0;
  int m_done = 0;

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    phase_t nx;
    bit over;
    if (!rst_n) begin
      m_ph = P_LOAD_A; m_el = 0; m_idx = 0; m_op = 0; m_done = 0;
    end else begin
      nx = m_ph;
      m_done = 0;
      over = step_mode ? advance : (m_el + 1 >= DISP);
      case (m_ph)
        P_LOAD_A: nx = skip ? P_ABORT : P_LOAD_B;
        P_LOAD_B: nx = skip ? P_ABORT : P_SHOW_A;
        P_SHOW_A: if (skip) nx = P_ABORT; else if (over) nx = P_SHOW_B;
        P_SHOW_B: if (skip) nx = P_ABORT; else if (over) nx = P_WAIT;
        P_WAIT: begin
          if (skip) nx = P_ABORT;
          else if (alu_btn != 0) begin m_op = lowest_set(alu_btn); nx = P_EXEC; end
        end
        P_EXEC: nx = P_SHOW_R;
        P_SHOW_R: begin
          if (skip || over) begin
            nx = P_LOAD_A;
            if (m_idx == N_OPS - 1) begin m_idx = 0; m_done = 1; end
            else m_idx = m_idx + 1;
          end
        end
        default: nx = P_LOAD_A;
      endcase
      m_el = (nx != m_ph) ? 0 : m_el + 1;
      m_ph = nx;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    int b, e_mux, e_wr, e_wl, e_rd, e_rs1, e_rs2, e_alu, e_led, e_disp, e_idx, e_done;
    b = (3 * m_idx) % (1 << REG_AW);
    e_mux = 0; e_wr = 0; e_wl = 0; e_rd = 0; e_rs1 = 0; e_rs2 = 0;
    e_alu = 0; e_led = 0; e_disp = 0; e_idx = 0; e_done = 0;
    if (rst_n) begin
      e_idx = m_idx;
      e_done = m_done;
      case (m_ph)
        P_LOAD_A: begin e_wl = 1; e_wr = 1; e_rd = b; end
        P_LOAD_B: begin e_wl = 1; e_wr = 1; e_rd = (b + 1) % 32; end
        P_SHOW_A: begin e_disp = 1; e_rs2 = b; e_led = 1; end
        P_SHOW_B: begin e_disp = 1; e_rs2 = (b + 1) % 32; e_led = 2; end
        P_WAIT:   begin e_rs1 = b; e_rs2 = (b + 1) % 32; end
        P_EXEC: begin
          e_mux = 1; e_wr = 1; e_rd = (b + 2) % 32; e_rs1 = b; e_rs2 = (b + 1) % 32;
          e_alu = m_op; e_led = 4 << m_op;
        end
        P_SHOW_R: begin e_disp = 1; e_rs2 = (b + 2) % 32; e_alu = m_op; e_led = 4 << m_op; end
        default: ;
      endcase
    end
    check("m_muxctrl", int'(muxctrl), e_mux);
    check("m_we_reg", int'(we_reg), e_wr);
    check("m_we_lfsr", int'(we_lfsr), e_wl);
    check("m_addr_rd", int'(addr_rd), e_rd);
    check("m_addr_rs1", int'(addr_rs1), e_rs1);
    check("m_addr_rs2", int'(addr_rs2), e_rs2);
    check("m_aluctrl", int'(aluctrl), e_alu);
    check("m_leds", int'(leds), e_led);
    check("m_displayctrl", int'(displayctrl), e_disp);
    check("m_op_idx", int'(op_idx), e_idx);
    check("m_done", int'(done), e_done);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int done_cnt;
    int held_bad;

    tick(3);
    check("rst_we_reg", int'(we_reg), 0);
    check("rst_we_lfsr", int'(we_lfsr), 0);
    rst_n = 1'b1;
    alu_btn = 4'b0100;
    #1;
    check("first_load_a_rd", int'(addr_rd), 0);
    check("first_load_a_we", int'(we_lfsr), 1);
    tick(1);
    check("load_b_rd", int'(addr_rd), 1);
    tick(6);
    check("exec_rd", int'(addr_rd), 2);
    check("exec_aluctrl", int'(aluctrl), 2);
    check("exec_leds", int'(leds), 6'b010000);
    check("exec_mux", int'(muxctrl), 1);
    tick(3);
    check("op1_idx", int'(op_idx), 1);
    check("op1_rd", int'(addr_rd), 3);
    check("model_idx_op1", m_idx, 1);

    // latched code survives the button being released
    alu_btn = 4'b0000;
    tick(6);
    alu_btn = 4'b1010;
    tick(1);
    check("btn1010_aluctrl", int'(aluctrl), 1);
    check("btn1010_leds", int'(leds), 6'b001000);
    alu_btn = 4'b0000;
    tick(1);
    check("show_r_aluctrl", int'(aluctrl), 1);
    check("show_r_rs2", int'(addr_rs2), 5);
    tick(2);
    check("op2_idx", int'(op_idx), 2);

    // skip in SHOW_B, then in EXEC and SHOW_R
    tick(4);
    check("show_b_leds", int'(leds), 6'b000010);
    skip = 1'b1;
    tick(1);
    check("abort_we_reg", int'(we_reg), 0);
    check("abort_leds", int'(leds), 0);
    check("abort_disp", int'(displayctrl), 0);
    skip = 1'b0;
    tick(1);
    check("reload_rd", int'(addr_rd), 6);
    check("reload_idx", int'(op_idx), 2);
    alu_btn = 4'b0001;
    tick(7);
    skip = 1'b1;
    #1;
    check("skip_exec_we", int'(we_reg), 1);
    check("skip_exec_rd", int'(addr_rd), 8);
    tick(1);
    check("skip_showr_rs2", int'(addr_rs2), 8);
    tick(1);
    check("skip_showr_idx", int'(op_idx), 3);
    skip = 1'b0;

    // reset during SHOW_R of op 3
    tick(8);
    check("op3_showr_disp", int'(displayctrl), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_we_reg", int'(we_reg), 0);
    check("midrst_we_lfsr", int'(we_lfsr), 0);
    check("midrst_disp", int'(displayctrl), 0);
    check("midrst_leds", int'(leds), 0);
    check("midrst_rs2", int'(addr_rs2), 0);
    check("midrst_idx", int'(op_idx), 0);
    tick(1);
    rst_n = 1'b1;
    #1;
    check("postrst_idx", int'(op_idx), 0);
    check("postrst_rd", int'(addr_rd), 0);
    check("postrst_we_lfsr", int'(we_lfsr), 1);

    // ten operations: single done pulse on the 9 -> 0 wrap
    done_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      if (done) done_cnt++;
      if (k == 90) check("op9_idx", int'(op_idx), 9);
      if (k == 97) begin
        check("op9_exec_rd", int'(addr_rd), 29);
        check("op9_exec_we", int'(we_reg), 1);
      end
      if (k == 100) begin
        check("wrap_idx", int'(op_idx), 0);
        check("wrap_done", int'(done), 1);
      end
    end
    check("done_pulses", done_cnt, 1);

    // single-step hold
    step_mode = 1'b1;
    advance = 1'b0;
    tick(2);
    held_bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (leds != 6'b000001) held_bad++;
    end
    check("step_hold_cycles", held_bad, 0);
    advance = 1'b1;
    tick(1);
    check("step_advance_leds", int'(leds), 6'b000010);
    advance = 1'b0;
    step_mode = 1'b0;

    // random phase
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      rst_n = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      alu_btn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      skip = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
      advance = ($urandom_range(0, 2) == 0);
    end
    rst_n = 1'b1;
    skip = 1'b0;
    step_mode = 1'b0;
    advance = 1'b0;
    alu_btn = 4'b0000;
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
